// File: rtl/apb_pwm_capture_if.sv
// APB bus bundle for the PWM input-capture peripheral.
// The master drives select/address/control/write data; the slave returns read data and handshake.
interface apb_pwm_capture_if;
    logic        PSEL;
    logic [15:0] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_pwm_capture.sv
// APB input-capture unit: measures period and high time of CAP_IN in PCLKG cycles,
// with done/overrun/timeout status and a maskable level interrupt.
module apb_pwm_capture #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             PCLKG,
    input  logic             PRESETn,
    apb_pwm_capture_if.slave apb,
    input  logic             CAP_IN,
    output logic             CAPINT
);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    localparam logic [9:0] OFF_CTRL    = 10'h000;
    localparam logic [9:0] OFF_STATUS  = 10'h001;
    localparam logic [9:0] OFF_PERIOD  = 10'h002;
    localparam logic [9:0] OFF_HIGH    = 10'h003;
    localparam logic [9:0] OFF_TIMEOUT = 10'h004;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [2:0]             ctrl_q;      // {inv, int_en, en}
    logic [2:0]             status_q;    // {tmo, ovr, done}
    logic [CNT_W-1:0]       period_q, high_q, timeout_q, high_tmp_q, cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    logic       wr_setup, ctrl_wr, status_wr, timeout_wr;
    logic [9:0] word;
    logic       ctrl_en, ctrl_int_en, ctrl_inv;
    logic       sig, rise, fall, tmo_hit;
    logic       capture, hi_latch, tmo_evt;
    logic [2:0] status_set, status_clr;
    logic [31:0] rdata;
    logic       unused_bits;

    assign ctrl_en     = ctrl_q[0];
    assign ctrl_int_en = ctrl_q[1];
    assign ctrl_inv    = ctrl_q[2];

    assign word       = apb.PADDR[11:2];
    assign wr_setup   = apb.PSEL & apb.PWRITE & ~apb.PENABLE;
    assign ctrl_wr    = wr_setup && (word == OFF_CTRL);
    assign status_wr  = wr_setup && (word == OFF_STATUS);
    assign timeout_wr = wr_setup && (word == OFF_TIMEOUT);

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign unused_bits = &{1'b0, apb.PADDR[15:12], apb.PADDR[1:0], apb.PWDATA};

    // Polarity is applied after the synchronizer so INV never touches the metastable stages.
    assign sig  = sync_q[SYNC_STAGES-1] ^ ctrl_inv;
    assign rise = sig & ~prev_q;
    assign fall = ~sig & prev_q;

    assign tmo_hit = (timeout_q != '0) && (cnt_q == timeout_q) && !rise && !fall;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        capture  = 1'b0;
        hi_latch = 1'b0;
        tmo_evt  = 1'b0;
        unique case (state_q)
            IDLE: if (ctrl_en && rise) state_d = HI;
            HI: begin
                if (fall) begin
                    state_d  = LO;
                    hi_latch = 1'b1;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    tmo_evt = 1'b1;
                end
            end
            LO: begin
                if (rise) begin
                    state_d = HI;
                    capture = 1'b1;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    tmo_evt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Disabling or reprogramming abandons the measurement in progress.
        if (!ctrl_en || ctrl_wr) begin
            state_d  = IDLE;
            capture  = 1'b0;
            hi_latch = 1'b0;
            tmo_evt  = 1'b0;
        end
    end

    assign status_set = {tmo_evt, capture & status_q[0], capture};
    assign status_clr = status_wr ? apb.PWDATA[2:0] : 3'b000;

    always_ff @(posedge PCLKG or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            status_q   <= '0;
            period_q   <= '0;
            high_q     <= '0;
            timeout_q  <= '0;
            high_tmp_q <= '0;
            cnt_q      <= '0;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            CAPINT     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], CAP_IN};
            prev_q  <= sig;

            if (ctrl_wr)    ctrl_q    <= apb.PWDATA[2:0];
            if (timeout_wr) timeout_q <= apb.PWDATA[CNT_W-1:0];

            if (ctrl_wr)                 cnt_q <= '0;
            else if (rise)               cnt_q <= CNT_W'(1);
            else if (state_q == IDLE)    cnt_q <= '0;
            else if (cnt_q != CNT_MAX)   cnt_q <= cnt_q + CNT_W'(1);

            if (hi_latch) high_tmp_q <= cnt_q;
            // PERIOD and HIGH update together so software always reads a coherent pair.
            if (capture) begin
                period_q <= cnt_q;
                high_q   <= high_tmp_q;
            end

            status_q <= (status_q & ~status_clr) | status_set;
            CAPINT   <= ctrl_int_en & (|status_q);
        end
    end

    always_comb begin
        rdata = '0;
        if (apb.PSEL && !apb.PWRITE) begin
            case (word)
                OFF_CTRL:    rdata = {29'b0, ctrl_q};
                OFF_STATUS:  rdata = {29'b0, status_q};
                OFF_PERIOD:  rdata = 32'(period_q);
                OFF_HIGH:    rdata = 32'(high_q);
                OFF_TIMEOUT: rdata = 32'(timeout_q);
                default:     rdata = '0;
            endcase
        end
    end

    assign apb.PRDATA = rdata;

endmodule

// File: tb/tb_apb_pwm_capture.sv
// Directed bench for apb_pwm_capture: the stimulus pushes the register values it implies onto
// a scoreboard queue, and APB reads pop and compare them.
module tb_apb_pwm_capture;

    localparam logic [15:0] A_CTRL    = 16'h0000;
    localparam logic [15:0] A_STATUS  = 16'h0004;
    localparam logic [15:0] A_PERIOD  = 16'h0008;
    localparam logic [15:0] A_HIGH    = 16'h000C;
    localparam logic [15:0] A_TIMEOUT = 16'h0010;
    localparam logic [15:0] A_UNMAP   = 16'h0014;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic pclkg   = 1'b0;
    logic presetn = 1'b0;
    logic cap_in  = 1'b0;
    logic capint;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    exp_t exp_q[$];

    apb_pwm_capture_if apb ();

    apb_pwm_capture #(.CNT_W(32), .SYNC_STAGES(2)) dut (
        .PCLKG  (pclkg),
        .PRESETn(presetn),
        .apb    (apb),
        .CAP_IN (cap_in),
        .CAPINT (capint)
    );

    always #5 pclkg = ~pclkg;
    always @(posedge pclkg) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclkg);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        if (cyc > t) begin
            errors++;
            $error("FAIL schedule: cycle %0d already past target %0d", cyc, t);
        end
        while (cyc < t) tick(1);
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic apb_write(input logic [15:0] addr, input logic [31:0] data);
        apb.PSEL    = 1'b1;
        apb.PADDR   = addr;
        apb.PWRITE  = 1'b1;
        apb.PWDATA  = data;
        apb.PENABLE = 1'b0;
        tick(1);
        apb.PENABLE = 1'b1;
        tick(1);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] addr, output logic [31:0] data);
        apb.PSEL    = 1'b1;
        apb.PADDR   = addr;
        apb.PWRITE  = 1'b0;
        apb.PENABLE = 1'b0;
        tick(1);
        apb.PENABLE = 1'b1;
        @(negedge pclkg);
        data = apb.PRDATA;
        tick(1);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic read_pop(input logic [15:0] addr);
        logic [31:0] d;
        exp_t        e;
        apb_read(addr, d);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: read of 0x%04h observed 0x%08h with nothing expected", addr, d);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, d, e.val);
        end
    endtask

    initial begin
        int t0, r, q;
        apb.PSEL = 1'b0; apb.PADDR = '0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PWDATA = '0;
        tick(3);
        presetn = 1'b1;
        tick(2);

        // Reset state and unmapped/RO write behaviour
        for (int a = 0; a < 6; a++) begin
            push($sformatf("reset_rd_0x%02h", a * 4), 32'h0);
            read_pop(16'(a * 4));
        end
        check("reset_capint", {31'b0, capint}, 32'h0);
        check("pready", {31'b0, apb.PREADY}, 32'h1);
        check("pslverr", {31'b0, apb.PSLVERR}, 32'h0);
        apb_write(A_PERIOD, 32'h0000_1234);
        apb_write(A_UNMAP, 32'hFFFF_FFFF);
        push("ro_period_write", 32'h0);
        push("unmapped_write", 32'h0);
        read_pop(A_PERIOD);
        read_pop(A_UNMAP);

        // Period 100 / high 30 with interrupt enabled
        apb_write(A_CTRL, 32'h3);
        push("ctrl_rd", 32'h3);
        read_pop(A_CTRL);
        t0 = cyc;
        cap_in = 1'b1;
        wait_until(t0 + 30);  cap_in = 1'b0;
        wait_until(t0 + 100); cap_in = 1'b1;
        push("cap1_status", 32'h1);
        push("cap1_period", 32'd100);
        push("cap1_high", 32'd30);
        tick(3);
        check("capint_before_done", {31'b0, capint}, 32'h0);
        tick(1);
        check("capint_after_done", {31'b0, capint}, 32'h1);
        read_pop(A_STATUS);
        read_pop(A_PERIOD);
        read_pop(A_HIGH);

        // Second capture with DONE still set: overrun
        wait_until(t0 + 130); cap_in = 1'b0;
        wait_until(t0 + 200); cap_in = 1'b1;
        push("ovr_status", 32'h3);
        push("ovr_period", 32'd100);
        tick(5);
        read_pop(A_STATUS);
        read_pop(A_PERIOD);

        // W1C clear; CAPINT follows one cycle later
        apb.PSEL = 1'b1; apb.PADDR = A_STATUS; apb.PWRITE = 1'b1; apb.PWDATA = 32'h3; apb.PENABLE = 1'b0;
        tick(1);
        check("capint_hold_after_clear", {31'b0, capint}, 32'h1);
        apb.PENABLE = 1'b1;
        tick(1);
        check("capint_drop_after_clear", {31'b0, capint}, 32'h0);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        push("cleared_status", 32'h0);
        read_pop(A_STATUS);

        wait_until(t0 + 230); cap_in = 1'b0;
        wait_until(t0 + 300); cap_in = 1'b1;
        push("cap4_status", 32'h1);
        tick(5);
        read_pop(A_STATUS);

        // Clear of DONE landing on the same edge as a capture: set wins
        wait_until(t0 + 330); cap_in = 1'b0;
        wait_until(t0 + 400); cap_in = 1'b1;
        r = cyc;
        tick(2);
        apb_write(A_STATUS, 32'h1);
        push("set_wins_status", 32'h3);
        push("set_wins_period", 32'd100);
        push("set_wins_high", 32'd30);
        read_pop(A_STATUS);
        read_pop(A_PERIOD);
        read_pop(A_HIGH);

        // Timeout: input stuck high, counter reaches 50
        apb_write(A_STATUS, 32'h7);
        apb_write(A_TIMEOUT, 32'd50);
        wait_until(r + 50);
        push("tmo_not_yet", 32'h0);
        read_pop(A_STATUS);
        push("tmo_status", 32'h4);
        read_pop(A_STATUS);
        check("capint_tmo", {31'b0, capint}, 32'h1);
        apb_write(A_STATUS, 32'h7);
        check("capint_tmo_cleared", {31'b0, capint}, 32'h0);

        cap_in = 1'b0;
        tick(5);
        q = cyc;
        cap_in = 1'b1;
        wait_until(q + 15); cap_in = 1'b0;
        wait_until(q + 40); cap_in = 1'b1;
        push("post_tmo_status", 32'h1);
        push("post_tmo_period", 32'd40);
        push("post_tmo_high", 32'd15);
        tick(5);
        read_pop(A_STATUS);
        read_pop(A_PERIOD);
        read_pop(A_HIGH);

        // Inverted input, interrupt masked: period 64 with CAP_IN high 16
        apb_write(A_TIMEOUT, 32'h0);
        apb_write(A_CTRL, 32'h5);
        apb_write(A_STATUS, 32'h7);
        tick(2);
        r = cyc;
        cap_in = 1'b0;
        wait_until(r + 48); cap_in = 1'b1;
        wait_until(r + 64); cap_in = 1'b0;
        push("inv_status", 32'h1);
        push("inv_period", 32'd64);
        push("inv_high", 32'd48);
        tick(5);
        check("capint_masked", {31'b0, capint}, 32'h0);
        read_pop(A_STATUS);
        read_pop(A_PERIOD);
        read_pop(A_HIGH);

        // Asynchronous reset in the middle of a measurement
        tick(10);
        presetn = 1'b0;
        tick(2);
        check("capint_in_reset", {31'b0, capint}, 32'h0);
        presetn = 1'b1;
        tick(2);
        push("rst2_ctrl", 32'h0);
        push("rst2_status", 32'h0);
        push("rst2_period", 32'h0);
        push("rst2_high", 32'h0);
        push("rst2_timeout", 32'h0);
        read_pop(A_CTRL);
        read_pop(A_STATUS);
        read_pop(A_PERIOD);
        read_pop(A_HIGH);
        read_pop(A_TIMEOUT);

        // EN cleared mid-measurement: no DONE, previous result kept
        apb_write(A_CTRL, 32'h3);
        tick(3);
        r = cyc;
        cap_in = 1'b1;
        wait_until(r + 20); cap_in = 1'b0;
        wait_until(r + 80); cap_in = 1'b1;
        push("en_cap_status", 32'h1);
        push("en_cap_period", 32'd80);
        push("en_cap_high", 32'd20);
        tick(5);
        read_pop(A_STATUS);
        read_pop(A_PERIOD);
        read_pop(A_HIGH);
        apb_write(A_STATUS, 32'h7);
        wait_until(r + 100); cap_in = 1'b0;
        wait_until(r + 120); apb_write(A_CTRL, 32'h0);
        wait_until(r + 160); cap_in = 1'b1;
        tick(10);
        push("en_off_status", 32'h0);
        push("en_off_period", 32'd80);
        push("en_off_high", 32'd20);
        push("en_off_ctrl", 32'h0);
        read_pop(A_STATUS);
        read_pop(A_PERIOD);
        read_pop(A_HIGH);
        read_pop(A_CTRL);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard: %0d expectations never compared", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_pwm_capture.md
Name: apb_pwm_capture

Overview:
- APB slave input-capture unit: measures period and high time of an external PWM/pulse input (the receive side of the PWM timer output) in PCLKG cycles.
- Captured values are readable over APB; completion, overrun and timeout raise a maskable interrupt.
- Sits on the APB peripheral bus alongside the timer; CAP_IN is asynchronous to PCLKG.

Parameters:
- CNT_W, 32, width of cycle counter and captured values (max 32).
- SYNC_STAGES, 2, synchronizer flops on CAP_IN (min 2).

Ports:
- PCLKG  input  1  APB/peripheral clock, all logic.
- PRESETn  input  1  reset, asynchronous, active-low.
- PSEL  input  1  device select.
- PADDR  input  16  address; PADDR[11:2] decoded.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  write control.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- PREADY  output  1  constant 1.
- PSLVERR  output  1  constant 0.
- CAP_IN  input  1  asynchronous pulse input.
- CAPINT  output  1  interrupt, level, registered.

Behaviour:
- Register map (byte offset):
  - 0x00 CTRL RW: [0] EN, [1] INT_EN, [2] INV (invert CAP_IN after sync).
  - 0x04 STATUS R/W1C: [0] DONE, [1] OVR, [2] TMO.
  - 0x08 PERIOD RO [CNT_W-1:0].
  - 0x0C HIGH RO [CNT_W-1:0].
  - 0x10 TIMEOUT RW [CNT_W-1:0]; 0 disables timeout.
- Reset: all registers 0, CAPINT=0, state IDLE, counter 0, sync chain 0.
- Writes take effect in setup phase only (PSEL & PWRITE & ~PENABLE). Writes to RO or unmapped offsets are ignored.
- Reads: PRDATA = selected register, zero-extended, combinational, when PSEL & ~PWRITE; otherwise 0. Unmapped offsets read 0.
- Input path: CAP_IN → SYNC_STAGES flops → XOR INV → prev flop.
  - rise = s & ~prev; fall = ~s & prev.
  - Latency from CAP_IN edge to detect: SYNC_STAGES+1 cycles.
- Counter cnt:
  - On rise: cnt <= 1; otherwise cnt <= cnt+1 while state≠IDLE.
  - Saturates at all-ones, no wrap.
  - In IDLE, cnt <= 0.
- FSM:
  - IDLE: EN=1 & rise → HI.
  - HI: fall → LO, with high_tmp <= cnt. Rise (input glitch shorter than detection) is not possible; ignore.
  - LO: rise → HI, with PERIOD <= cnt, HIGH <= high_tmp (same cycle, coherent pair), DONE set.
  - HI/LO: TIMEOUT≠0 & cnt==TIMEOUT & no edge this cycle → IDLE, TMO set, PERIOD/HIGH unchanged.
  - EN=0 → IDLE next cycle from any state. Any CTRL write → IDLE next cycle, cnt 0.
- Result: period N, high H cycles → PERIOD=N, HIGH=H. The first capture needs two rising edges after enable.
- Status bits:
  - OVR set on a capture while DONE already 1; PERIOD/HIGH are still overwritten.
  - W1C: writing 1 clears that bit. A set and a clear in the same cycle: set wins.
- CAPINT <= INT_EN & (DONE|OVR|TMO), one cycle after the status change.
- Reset mid-capture: asynchronous return to reset state, no capture.

Test Plan:
- Reset, read all offsets → 0x00..0x10 all read 0. CAPINT=0, PREADY=1, PSLVERR=0.
- CTRL=0x3, CAP_IN period 100 / high 30 cycles, 3 periods → PERIOD=100, HIGH=30, STATUS=0x1 after 2nd rise; CAPINT high one cycle after DONE.
- Leave DONE uncleared through next capture → STATUS=0x3. Write 0x3 to STATUS → 0x0, CAPINT drops next cycle. Clear coinciding with a capture → DONE remains 1.
- TIMEOUT=50, CAP_IN held high after a rise → TMO set at cnt==50, state IDLE. Next full period captures correctly.
- CTRL=0x5 (INV), period 64 / high 16 → HIGH=48, PERIOD=64.
- Assert PRESETn low mid-period → all registers 0. Clear EN mid-capture → no DONE, PERIOD retains previous value.
